instr_encoder: RTL and testbench
================================

# instr_encoder

Packs decoded instruction fields (opcode, rde, rs1, rs2, func, imm) into 32-bit Aphelion instruction words, the inverse of the instruction decoder. It sits between the boot/debug loader or test sequencer and the instruction-memory write port. It accepts one field set per valid/ready handshake, checks field legality, assigns a sequential word address and buffers results in a 2-entry output FIFO.

## Interface
- ADDR_W, 16: width of the word-address counter
- ERR_DROP, 1: 1 = illegal instructions are dropped (not emitted, address not advanced); 0 = emitted with out_err=1
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  field set valid
- in_ready  output  1  encoder can accept (FIFO not full)
- in_opcode  input  8  opcode; instr type = in_opcode[2:0]
- in_rde, in_rs1, in_rs2, in_func  input  4 each  register/function fields
- in_imm  input  24  immediate, right-aligned
- addr_clr  input  1  synchronous clear of address counter
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer takes head
- out_word  output  32  encoded instruction
- out_addr  output  ADDR_W  word address of out_word
- out_err  output  1  head is illegal (only when ERR_DROP=0)
- err_sticky  output  1  set on any illegal accept, cleared only by reset
- err_count  output  8  illegal accepts, saturates at 255

## Operation
- Accept when in_valid && in_ready. Word bits [7:0] = in_opcode always. Type-dependent packing, unused bits 0:
  - E (0): imm[7:0]→[15:8], func→[19:16], rs2→[23:20], rs1→[27:24], rde→[31:28]
  - R (1): imm[11:0]→[19:8], rs2, rs1, rde as E
  - M (2): imm[11:0]→[19:8], func→[23:20], rs1, rde
  - I (3): imm[15:0]→[23:8], rs1, rde
  - F (4): imm[15:0]→[23:8], func→[27:24], rde
  - B (5): imm[19:0]→[27:8], func→[31:28]
  - U (6): imm[23:0]→[31:8]
- Illegal if type = 7, or in_imm bits above the field width are neither all 0 nor all equal to the field MSB (sign extension). U never overflows.
- Illegal accept: err_sticky←1 and err_count+1, saturating. With ERR_DROP=1, nothing is written to the FIFO and the address is unchanged. With ERR_DROP=0, the entry is written with out_err=1 and consumes an address.
- Address: the current counter is assigned at accept and the counter increments by 1 per emitted entry, wrapping 2^ADDR_W−1→0. addr_clr has priority. A word accepted in the same cycle as addr_clr gets address 0 and the counter becomes 1 (0 if dropped).
- FIFO: 2 entries, count 0..2. in_ready = (count<2) || (out_valid && out_ready), so the FIFO can pass through when full. Simultaneous push and pop: count unchanged, order preserved.

## Timing
- Reset values: out_valid 0, out_word 0, out_addr 0, out_err 0, err_sticky 0, err_count 0, address counter 0, FIFO empty, in_ready 1.
- Latency: accept in cycle N → out_valid=1 with that word in cycle N+1 (FIFO was empty).
- out_word, out_addr and out_err are stable while out_valid && !out_ready. out_valid never drops without a pop.
- Throughput: 1 word/cycle with out_ready held high. With out_ready low, exactly 2 accepts occur, then in_ready=0.
- Reset asserted mid-operation: FIFO contents discarded immediately and all outputs return to reset values asynchronously.

## Test plan
- E-type: opcode 0x10, imm 0xAB, func 3, rs2 2, rs1 1, rde 4 → out_word 0x4123AB10, out_addr 0, out_valid one cycle after accept.
- I then U back-to-back, out_ready=1: I-type opcode 0x23, rde 5, rs1 6, imm 0x001234 → 0x56123423 @ addr 0; U-type opcode 0x46, imm 0xABCDEF → 0xABCDEF46 @ addr 1.
- Backpressure: out_ready=0, 3 valid inputs → 2 accepted, in_ready=0. Release out_ready → words emitted in order, third accepted on the first pop cycle.
- Illegal, ERR_DROP=1: R-type opcode 0x01, imm 0x001000 → no output, err_sticky=1, err_count=1, next legal word keeps the previous address. Opcode 0x07 → err_count=2. Sign-extended imm 0xFFF800 on R-type → legal, field 0x800.
- Illegal, ERR_DROP=0: opcode 0x07 → emitted with out_err=1 and consumes an address.
- Address: preload counter to 2^ADDR_W−1 → wraps to 0. addr_clr with a simultaneous accept → that word gets addr 0, next gets addr 1. Assert rst_n low with 2 entries queued → out_valid=0 immediately.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded instruction fields into 32-bit Aphelion words,
// checks field legality, numbers each emitted word with a sequential address
// and queues results in a 2-entry output FIFO.
module instr_encoder #(
  parameter int ADDR_W   = 16,
  parameter bit ERR_DROP = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_opcode,
  input  logic [3:0]        in_rde,
  input  logic [3:0]        in_rs1,
  input  logic [3:0]        in_rs2,
  input  logic [3:0]        in_func,
  input  logic [23:0]       in_imm,
  input  logic              addr_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              err_sticky,
  output logic [7:0]        err_count
);

  localparam logic [2:0] T_E = 3'd0;
  localparam logic [2:0] T_R = 3'd1;
  localparam logic [2:0] T_M = 3'd2;
  localparam logic [2:0] T_I = 3'd3;
  localparam logic [2:0] T_F = 3'd4;
  localparam logic [2:0] T_B = 3'd5;
  localparam logic [2:0] T_U = 3'd6;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Width of the immediate field carried by each instruction type.
  function automatic logic [4:0] imm_width(input logic [2:0] t);
    case (t)
      T_E:      imm_width = 5'd8;
      T_R, T_M: imm_width = 5'd12;
      T_I, T_F: imm_width = 5'd16;
      T_B:      imm_width = 5'd20;
      default:  imm_width = 5'd24;
    endcase
  endfunction

  // The bits above the field must be all zero or a sign extension of the
  // field MSB; a 24-bit field leaves nothing above it and always fits.
  function automatic logic imm_fits(input logic [23:0] imm, input logic [4:0] w);
    logic [23:0] hi_mask;
    logic [23:0] upper;
    hi_mask  = ~((24'd1 << w) - 24'd1);
    upper    = imm & hi_mask;
    imm_fits = (upper == 24'd0) || (imm[w - 5'd1] && (upper == hi_mask));
  endfunction

  // Type-dependent bit placement; unused bits stay zero.
  function automatic logic [31:0] pack_word(input logic [7:0]  op,
                                            input logic [3:0]  rde,
                                            input logic [3:0]  rs1,
                                            input logic [3:0]  rs2,
                                            input logic [3:0]  func,
                                            input logic [23:0] imm);
    logic [31:0] w;
    w      = 32'd0;
    w[7:0] = op;
    case (op[2:0])
      T_E: begin
        w[15:8]  = imm[7:0];
        w[19:16] = func;
        w[23:20] = rs2;
        w[27:24] = rs1;
        w[31:28] = rde;
      end
      T_R: begin
        w[19:8]  = imm[11:0];
        w[23:20] = rs2;
        w[27:24] = rs1;
        w[31:28] = rde;
      end
      T_M: begin
        w[19:8]  = imm[11:0];
        w[23:20] = func;
        w[27:24] = rs1;
        w[31:28] = rde;
      end
      T_I: begin
        w[23:8]  = imm[15:0];
        w[27:24] = rs1;
        w[31:28] = rde;
      end
      T_F: begin
        w[23:8]  = imm[15:0];
        w[27:24] = func;
        w[31:28] = rde;
      end
      T_B: begin
        w[27:8]  = imm[19:0];
        w[31:28] = func;
      end
      T_U: w[31:8] = imm;
      default: ;
    endcase
    pack_word = w;
  endfunction

  logic [1:0]        count_q, count_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_base;
  logic              err_sticky_q, err_sticky_d;
  logic [7:0]        err_count_q, err_count_d;

  logic [31:0]       word_mem_q [2];
  logic [ADDR_W-1:0] addr_mem_q [2];
  logic              err_mem_q  [2];

  logic [31:0]       enc_word;
  logic              illegal;
  logic              accept;
  logic              push;
  logic              pop;

  assign enc_word  = pack_word(in_opcode, in_rde, in_rs1, in_rs2, in_func, in_imm);
  assign illegal   = (in_opcode[2:0] == 3'd7) ||
                     !imm_fits(in_imm, imm_width(in_opcode[2:0]));
  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign in_ready  = (count_q != 2'd2) || pop;
  assign accept    = in_valid && in_ready;
  assign push      = accept && !(illegal && ERR_DROP);

  // Outputs read as zero when the FIFO is empty, so storage needs no reset.
  assign out_word   = out_valid ? word_mem_q[rd_ptr_q] : 32'd0;
  assign out_addr   = out_valid ? addr_mem_q[rd_ptr_q] : '0;
  assign out_err    = out_valid ? err_mem_q[rd_ptr_q]  : 1'b0;
  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;

  // Next-state for FIFO pointers/occupancy, address counter and error status.
  always_comb begin
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    err_sticky_d = err_sticky_q;
    err_count_d  = err_count_q;
    addr_base    = addr_clr ? '0 : addr_q;
    addr_d       = push ? (addr_base + ADDR_ONE) : addr_base;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: ;
    endcase
    if (accept && illegal) begin
      err_sticky_d = 1'b1;
      if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= 2'd0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      addr_q       <= '0;
      err_sticky_q <= 1'b0;
      err_count_q  <= 8'd0;
    end else begin
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      addr_q       <= addr_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
    end
  end

  // FIFO storage write; the entry takes the pre-increment address.
  always_ff @(posedge clk) begin
    if (push) begin
      word_mem_q[wr_ptr_q] <= enc_word;
      addr_mem_q[wr_ptr_q] <= addr_base;
      err_mem_q[wr_ptr_q]  <= illegal;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: a drop-mode instance (ADDR_W=16) and an
// emit-mode instance (ADDR_W=4) share the field inputs.
module tb_instr_encoder;

  logic        clk;
  logic        rst_n;
  logic [7:0]  op;
  logic [3:0]  rde, rs1, rs2, func;
  logic [23:0] imm;

  logic        va, ra, clr_a, ova, ora, ea, sta;
  logic [31:0] wa;
  logic [15:0] aa;
  logic [7:0]  cnta;

  logic        vb, rb, clr_b, ovb, orb, eb, stb;
  logic [31:0] wb;
  logic [3:0]  ab;
  logic [7:0]  cntb;

  int n_chk = 0;
  int n_err = 0;

  instr_encoder #(.ADDR_W(16), .ERR_DROP(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(va), .in_ready(ra),
    .in_opcode(op), .in_rde(rde), .in_rs1(rs1), .in_rs2(rs2), .in_func(func),
    .in_imm(imm), .addr_clr(clr_a), .out_valid(ova), .out_ready(ora),
    .out_word(wa), .out_addr(aa), .out_err(ea), .err_sticky(sta), .err_count(cnta));

  instr_encoder #(.ADDR_W(4), .ERR_DROP(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(vb), .in_ready(rb),
    .in_opcode(op), .in_rde(rde), .in_rs1(rs1), .in_rs2(rs2), .in_func(func),
    .in_imm(imm), .addr_clr(clr_b), .out_valid(ovb), .out_ready(orb),
    .out_word(wb), .out_addr(ab), .out_err(eb), .err_sticky(stb), .err_count(cntb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [3:0]  rde, rs1, rs2, func;
    logic [23:0] imm;
    logic [31:0] word;
  } vec_t;

  typedef struct {
    logic [31:0] w;
    logic [15:0] a;
  } exp_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic setf(input logic [7:0] o, input logic [3:0] d, input logic [3:0] s1,
                      input logic [3:0] s2, input logic [3:0] fn, input logic [23:0] im);
    op = o; rde = d; rs1 = s1; rs2 = s2; func = fn; imm = im;
  endtask

  task automatic setv(input vec_t v);
    setf(v.op, v.rde, v.rs1, v.rs2, v.func, v.imm);
  endtask

  // Reference model: field widths and bit positions straight from the
  // instruction-format table, computed with integer arithmetic.
  function automatic int unsigned fwidth(input int unsigned t);
    case (t)
      0:       return 8;
      1, 2:    return 12;
      3, 4:    return 16;
      5:       return 20;
      default: return 24;
    endcase
  endfunction

  function automatic bit m_legal(input logic [7:0] o, input logic [23:0] im);
    int unsigned t, w, hi, top, msb, v;
    t = o % 8;
    if (t == 7) return 1'b0;
    w = fwidth(t);
    if (w == 24) return 1'b1;
    v   = im;
    hi  = v / (1 << w);
    top = (1 << (24 - w)) - 1;
    msb = (v / (1 << (w - 1))) % 2;
    return (hi == 0) || ((hi == top) && (msb == 1));
  endfunction

  function automatic logic [31:0] m_encode(input logic [7:0] o, input logic [3:0] d,
                                           input logic [3:0] s1, input logic [3:0] s2,
                                           input logic [3:0] fn, input logic [23:0] im);
    longint unsigned t, f, w, D, S1, S2, FN;
    t = o % 8;
    f = im % (64'd1 << fwidth(t));
    D = d; S1 = s1; S2 = s2; FN = fn;
    w = o;
    case (t)
      0: w = w + (f << 8) + (FN << 16) + (S2 << 20) + (S1 << 24) + (D << 28);
      1: w = w + (f << 8) + (S2 << 20) + (S1 << 24) + (D << 28);
      2: w = w + (f << 8) + (FN << 20) + (S1 << 24) + (D << 28);
      3: w = w + (f << 8) + (S1 << 24) + (D << 28);
      4: w = w + (f << 8) + (FN << 24) + (D << 28);
      5: w = w + (f << 8) + (FN << 28);
      6: w = w + (f << 8);
      default: ;
    endcase
    return w[31:0];
  endfunction

  exp_t q[$];
  int   m_addr;
  int   m_cnt;
  bit   m_sticky;

  initial begin
    tbl[0] = '{8'h10, 4'h4, 4'h1, 4'h2, 4'h3, 24'h0000AB, 32'h4123AB10};
    tbl[1] = '{8'h23, 4'h5, 4'h6, 4'h0, 4'h0, 24'h001234, 32'h56123423};
    tbl[2] = '{8'h46, 4'h0, 4'h0, 4'h0, 4'h0, 24'hABCDEF, 32'hABCDEF46};
    tbl[3] = '{8'h01, 4'h9, 4'h8, 4'h7, 4'h0, 24'hFFF800, 32'h98780001};
    tbl[4] = '{8'h02, 4'hE, 4'h3, 4'h5, 4'hD, 24'h000ABC, 32'hE3DABC02};
    tbl[5] = '{8'h0C, 4'h1, 4'hF, 4'h0, 4'hA, 24'h00FFFF, 32'h1AFFFF0C};
    tbl[6] = '{8'h85, 4'h0, 4'h0, 4'h0, 4'h6, 24'hF80001, 32'h68000185};
    tbl[7] = '{8'hF8, 4'h4, 4'h3, 4'h2, 4'h1, 24'hFFFF80, 32'h432180F8};

    rst_n = 1'b0;
    va = 0; ora = 0; clr_a = 0; vb = 0; orb = 0; clr_b = 0;
    setf(8'h00, 0, 0, 0, 0, 24'h0);
    repeat (2) @(negedge clk);
    chk("rst_out_valid", ova, 0);
    chk("rst_in_ready", ra, 1);
    chk("rst_out_word", wa, 0);
    chk("rst_out_addr", aa, 0);
    chk("rst_out_err", ea, 0);
    chk("rst_sticky", sta, 0);
    chk("rst_count", cnta, 0);
    chk("rst_b_valid", ovb, 0);
    rst_n = 1'b1;

    // Table of legal encodings, one at a time, sequential addresses.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      setv(tbl[i]); va = 1; ora = 1;
      #1;
      if (i == 0) chk("lat_before", ova, 0);
      @(posedge clk); #1 va = 0;
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), ova, 1);
      chk($sformatf("tbl%0d_word", i), wa, tbl[i].word);
      chk($sformatf("tbl%0d_addr", i), aa, i);
      chk($sformatf("tbl%0d_err", i), ea, 0);
    end

    // Clear address, then I and U back-to-back.
    @(negedge clk); clr_a = 1;
    @(posedge clk); #1 clr_a = 0;
    @(negedge clk); setv(tbl[1]); va = 1; ora = 1;
    @(posedge clk);
    @(negedge clk);
    chk("iu_word0", wa, 32'h56123423);
    chk("iu_addr0", aa, 0);
    setv(tbl[2]);
    @(posedge clk); #1 va = 0;
    @(negedge clk);
    chk("iu_word1", wa, 32'hABCDEF46);
    chk("iu_addr1", aa, 1);
    @(posedge clk);

    // Backpressure: three offered, two accepted, third on the first pop.
    @(negedge clk); ora = 0; setv(tbl[3]); va = 1;
    #1 chk("bp_ready0", ra, 1);
    @(posedge clk); #1 setv(tbl[4]);
    @(negedge clk);
    chk("bp_ready1", ra, 1);
    chk("bp_head1", wa, tbl[3].word);
    @(posedge clk); #1 setv(tbl[5]);
    @(negedge clk);
    chk("bp_full", ra, 0);
    @(posedge clk);
    @(negedge clk);
    chk("bp_still_full", ra, 0);
    chk("bp_stable_word", wa, tbl[3].word);
    chk("bp_stable_addr", aa, 2);
    ora = 1;
    #1 chk("bp_passthru", ra, 1);
    @(posedge clk); #1 va = 0;
    @(negedge clk);
    chk("bp_word2", wa, tbl[4].word);
    chk("bp_addr2", aa, 3);
    @(posedge clk);
    @(negedge clk);
    chk("bp_word3", wa, tbl[5].word);
    chk("bp_addr3", aa, 4);
    @(posedge clk);
    @(negedge clk);
    chk("bp_empty", ova, 0);

    // Illegal with drop: nothing emitted, address held.
    setf(8'h01, 1, 2, 3, 4, 24'h001000); va = 1;
    @(posedge clk); #1 va = 0;
    @(negedge clk);
    chk("ill_no_out", ova, 0);
    chk("ill_sticky", sta, 1);
    chk("ill_count1", cnta, 1);
    setf(8'h07, 0, 0, 0, 0, 24'h0); va = 1;
    @(posedge clk); #1 va = 0;
    @(negedge clk);
    chk("ill_count2", cnta, 2);
    chk("ill_no_out2", ova, 0);
    setv(tbl[0]); va = 1;
    @(posedge clk); #1 va = 0;
    @(negedge clk);
    chk("ill_next_addr", aa, 5);
    chk("ill_next_word", wa, tbl[0].word);
    @(posedge clk);

    // addr_clr coincident with an accept.
    @(negedge clk); setv(tbl[1]); clr_a = 1; va = 1;
    @(posedge clk); #1 clr_a = 0; setv(tbl[2]);
    @(negedge clk);
    chk("clr_addr0", aa, 0);
    chk("clr_word0", wa, tbl[1].word);
    @(posedge clk); #1 va = 0;
    @(negedge clk);
    chk("clr_addr1", aa, 1);
    @(posedge clk);

    // Emit-mode instance: illegal entry flagged, consumes address, then wrap.
    @(negedge clk); setf(8'h07, 0, 0, 0, 0, 24'h0); vb = 1; orb = 1;
    @(posedge clk); #1 vb = 0;
    @(negedge clk);
    chk("b_err_valid", ovb, 1);
    chk("b_err_flag", eb, 1);
    chk("b_err_addr", ab, 0);
    chk("b_err_sticky", stb, 1);
    chk("b_err_count", cntb, 1);
    setv(tbl[0]); vb = 1;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      chk($sformatf("b_wrap_addr%0d", i), ab, i % 16);
      chk($sformatf("b_wrap_err%0d", i), eb, 0);
    end
    vb = 0;
    @(posedge clk);

    // Reset with two entries queued.
    @(negedge clk); ora = 0; setv(tbl[0]); va = 1;
    @(posedge clk);
    @(posedge clk); #1 va = 0;
    @(negedge clk);
    chk("mrst_pre_valid", ova, 1);
    chk("mrst_pre_full", ra, 0);
    #2 rst_n = 0;
    #1;
    chk("mrst_valid", ova, 0);
    chk("mrst_ready", ra, 1);
    chk("mrst_word", wa, 0);
    chk("mrst_addr", aa, 0);
    chk("mrst_sticky", sta, 0);
    chk("mrst_count", cnta, 0);
    @(negedge clk); rst_n = 1;

    // Randomized traffic against the reference model.
    m_addr = 0; m_cnt = 0; m_sticky = 0;
    for (int c = 0; c < 500; c++) begin
      bit iv, orr, clr, acc, pp, lg, exp_ready;
      logic [23:0] ri;
      int base;
      @(negedge clk);
      case ($urandom_range(0, 3))
        0: ri = 24'($urandom);
        1: ri = 24'($urandom_range(0, 4095));
        2: ri = 24'hFFF000 | 24'($urandom_range(0, 4095));
        default: ri = 24'hFF0000 | 24'($urandom_range(0, 65535));
      endcase
      setf(8'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), ri);
      iv  = ($urandom_range(0, 3) != 0);
      orr = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 19) == 0);
      va = iv; ora = orr; clr_a = clr;
      #1;
      exp_ready = (q.size() < 2) || (q.size() > 0 && orr);
      chk("rnd_ready", ra, exp_ready);
      chk("rnd_valid", ova, q.size() > 0);
      if (q.size() > 0) begin
        chk("rnd_word", wa, q[0].w);
        chk("rnd_addr", aa, q[0].a);
      end
      acc = iv && exp_ready;
      pp  = (q.size() > 0) && orr;
      lg  = m_legal(op, imm);
      if (pp) void'(q.pop_front());
      base = clr ? 0 : m_addr;
      if (acc && !lg) begin
        m_sticky = 1;
        if (m_cnt < 255) m_cnt++;
      end
      if (acc && lg) begin
        q.push_back('{m_encode(op, rde, rs1, rs2, func, imm), 16'(base)});
        m_addr = (base + 1) % 65536;
      end else begin
        m_addr = base;
      end
    end
    @(negedge clk); va = 0; clr_a = 0;
    chk("rnd_sticky", sta, m_sticky);
    chk("rnd_count", cnta, m_cnt);

    // Error counter saturation.
    ora = 1; setf(8'h07, 0, 0, 0, 0, 24'h0); va = 1;
    repeat (260) @(negedge clk);
    va = 0;
    @(negedge clk);
    chk("sat_count", cnta, 255);
    chk("sat_sticky", sta, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
